// File: rtl/dir_remap_pipe.sv
// Lane/bit remapping stage feeding a 2-entry in-order buffer with a completed-transfer counter.
// Handshake outputs and out_data derive only from registered state.
module dir_remap_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LANES = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*LANES-1:0]   in_data,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic [CNTW-1:0]          xfer_cnt
);

    localparam int unsigned D = WIDTH * LANES;

    logic [1:0]      count_q, count_d;
    logic [D-1:0]    head_q, head_d;
    logic [D-1:0]    tail_q, tail_d;
    logic [CNTW-1:0] xfer_q, xfer_d;
    logic [D-1:0]    remapped;
    logic            push, pop;

    function automatic logic [D-1:0] remap(input logic [D-1:0] d, input logic [1:0] m);
        logic [D-1:0] r;
        r = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                int idx;
                idx = k * int'(WIDTH) + b;
                unique case (m)
                    2'b00: r[idx] = d[idx];
                    2'b01: r[idx] = d[k * int'(WIDTH) + int'(WIDTH) - 1 - b];
                    2'b10: r[idx] = d[(int'(LANES) - 1 - k) * int'(WIDTH) + b];
                    default: r[idx] = d[int'(D) - 1 - idx];
                endcase
            end
        end
        return r;
    endfunction

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? head_q : '0;
    assign xfer_cnt  = xfer_q;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign remapped = remap(in_data, in_mode);

    // Pop is applied first so a simultaneous push lands in whichever slot is then free.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        xfer_d  = xfer_q;
        if (pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
            xfer_d  = xfer_q + CNTW'(1);
        end
        if (push) begin
            if (count_d == 2'd0) begin
                head_d = remapped;
            end else begin
                tail_d = remapped;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            xfer_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            xfer_q  <= xfer_d;
        end
    end

endmodule

// File: tb/tb_dir_remap_pipe.sv
// Bench for dir_remap_pipe: directed vector table, handshake corner sequences,
// and a randomized run on a 3x5 instance against a queue-based reference model.
module tb_dir_remap_pipe;

    logic clk;
    logic rst_n;

    // Instance A: WIDTH=4, LANES=2, CNTW=16
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data, a_out_data;
    logic [1:0]  a_in_mode;
    logic [15:0] a_xfer;

    // Instance C: WIDTH=5, LANES=3, CNTW=4
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [14:0] c_in_data, c_out_data;
    logic [1:0]  c_in_mode;
    logic [3:0]  c_xfer;

    int checks = 0;
    int errors = 0;

    dir_remap_pipe #(.WIDTH(4), .LANES(2), .CNTW(16)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .xfer_cnt  (a_xfer)
    );

    dir_remap_pipe #(.WIDTH(5), .LANES(3), .CNTW(4)) dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .in_mode   (c_in_mode),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_data  (c_out_data),
        .xfer_cnt  (c_xfer)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference remap: mode 11 is the composition of per-lane bit reversal and lane reversal.
    function automatic logic [31:0] rev_bits(input logic [31:0] x, input int w, input int l);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < l; k++)
            for (int b = 0; b < w; b++)
                r[k*w + b] = x[k*w + w - 1 - b];
        return r;
    endfunction

    function automatic logic [31:0] rev_lanes(input logic [31:0] x, input int w, input int l);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < l; k++)
            for (int b = 0; b < w; b++)
                r[k*w + b] = x[(l - 1 - k)*w + b];
        return r;
    endfunction

    function automatic logic [31:0] ref_remap(input logic [1:0] m, input logic [31:0] x,
                                              input int w, input int l);
        case (m)
            2'b00:   return x;
            2'b01:   return rev_bits(x, w, l);
            2'b10:   return rev_lanes(x, w, l);
            default: return rev_lanes(rev_bits(x, w, l), w, l);
        endcase
    endfunction

    task automatic idle_inputs();
        a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_in_mode = '0; c_out_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[7];

    logic [14:0] q[$];
    int          c_pops;
    logic        do_push, do_pop;
    logic [14:0] exp_word;

    initial begin
        tbl[0] = '{2'b00, 8'hA3, 8'hA3};
        tbl[1] = '{2'b01, 8'hA3, 8'h5C};
        tbl[2] = '{2'b10, 8'hA3, 8'h3A};
        tbl[3] = '{2'b11, 8'hA3, 8'hC5};
        tbl[4] = '{2'b01, 8'h01, 8'h08};
        tbl[5] = '{2'b10, 8'h12, 8'h21};
        tbl[6] = '{2'b11, 8'h01, 8'h80};

        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_xfer", a_xfer, 0);
        @(negedge clk);
        rst_n = 1;

        // Directed remap table, one push per cycle with out_ready held high
        foreach (tbl[i]) begin
            @(negedge clk);
            a_in_valid = 1; a_in_data = tbl[i].data; a_in_mode = tbl[i].mode; a_out_ready = 1;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", i), a_out_valid, 1);
            check($sformatf("tbl%0d_data", i), a_out_data, tbl[i].exp);
        end
        @(negedge clk);
        a_in_valid = 0;
        @(posedge clk); #1;
        check("tbl_drained", a_out_valid, 0);
        check("tbl_xfer", a_xfer, 7);

        // Backpressure: fill both entries, third offer ignored, then drain in order
        @(negedge clk);
        a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h11; a_in_mode = 2'b00;
        @(negedge clk);
        a_in_data = 8'h22;
        @(posedge clk); #1;
        check("bp_in_ready_full", a_in_ready, 0);
        check("bp_head", a_out_data, 8'h11);
        @(negedge clk);
        a_in_data = 8'h33;
        @(posedge clk); #1;
        check("bp_hold_data", a_out_data, 8'h11);
        check("bp_hold_ready", a_in_ready, 0);
        @(negedge clk);
        a_in_valid = 0; a_out_ready = 1;
        @(posedge clk); #1;
        check("bp_second", a_out_data, 8'h22);
        check("bp_ready_again", a_in_ready, 1);
        @(posedge clk); #1;
        check("bp_empty", a_out_valid, 0);
        check("bp_xfer", a_xfer, 9);

        // Asynchronous reset while full
        @(negedge clk);
        a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h44;
        @(negedge clk);
        a_in_data = 8'h55;
        @(posedge clk); #1;
        check("ar_full", a_in_ready, 0);
        #2 rst_n = 0;
        #1;
        check("ar_out_valid", a_out_valid, 0);
        check("ar_in_ready", a_in_ready, 1);
        check("ar_xfer", a_xfer, 0);
        check("ar_out_data", a_out_data, 0);
        @(posedge clk); #1;
        check("ar_no_push", a_out_valid, 0);
        @(negedge clk);
        rst_n = 1;
        a_in_valid = 1; a_in_data = 8'h0F; a_in_mode = 2'b11; a_out_ready = 1;
        @(posedge clk); #1;
        check("ar_post_valid", a_out_valid, 1);
        check("ar_post_data", a_out_data, 8'hF0);
        @(negedge clk);
        a_in_valid = 0;
        @(posedge clk); #1;
        check("ar_post_xfer", a_xfer, 1);

        // Streaming 100 words back to back
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a_in_valid = 1; a_in_data = 8'(i); a_in_mode = 2'b00; a_out_ready = 1;
            @(posedge clk); #1;
            check($sformatf("stream%0d_valid", i), a_out_valid, 1);
            check($sformatf("stream%0d_data", i), a_out_data, i);
        end
        @(negedge clk);
        a_in_valid = 0;
        @(posedge clk); #1;
        check("stream_xfer", a_xfer, 100);

        // 4-bit counter wrap on instance C
        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            c_in_valid = (i < 17); c_in_data = 15'(i); c_out_ready = 1;
            @(posedge clk); #1;
            if (i == 15) check("wrap_15", c_xfer, 15);
            if (i == 16) check("wrap_0", c_xfer, 0);
            if (i == 17) check("wrap_1", c_xfer, 1);
        end

        // Random traffic on instance C against the queue model
        do_reset();
        q.delete();
        c_pops = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            check("rnd_out_valid", c_out_valid, q.size() > 0);
            check("rnd_in_ready", c_in_ready, q.size() < 2);
            check("rnd_out_data", c_out_data, (q.size() > 0) ? q[0] : 15'd0);
            check("rnd_xfer", c_xfer, c_pops % 16);
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 2) != 0);
            c_in_data   = 15'($urandom);
            c_in_mode   = 2'($urandom);
            do_push  = c_in_valid && (q.size() < 2);
            do_pop   = (q.size() > 0) && c_out_ready;
            exp_word = 15'(ref_remap(c_in_mode, 32'(c_in_data), 5, 3));
            @(posedge clk);
            if (do_pop) begin
                void'(q.pop_front());
                c_pops++;
            end
            if (do_push) q.push_back(exp_word);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
